// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: ALU results take the port unconditionally, MDU results
// are buffered in a small in-order FIFO, and a busy scoreboard tracks pending MDU destinations.
module wb_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    output logic            mdu_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      chk_a1,
    input  logic [4:0]      chk_a2,
    output logic            busy1,
    output logic            busy2,
    output logic            issue_busy,
    output logic            rf_we,
    output logic [4:0]      rf_a3,
    output logic [XLEN-1:0] rf_wd3,
    output logic            err_waw
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [4:0]      q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic [PW:0]     count;
    logic [31:0]     busy, busy_next;
    logic            err_q;

    logic            fifo_empty, hs, sel_fifo, sel_direct, mdu_sel;
    logic            enq, deq, clr_en, set_en, issue_busy_int, waw_hit;
    logic [4:0]      mdu_sel_rd;
    logic [XLEN-1:0] mdu_sel_data;

    // mdu_ready depends only on the occupancy register, never on mdu_valid.
    assign mdu_ready = reset && (count < FULL);

    always_comb begin
        fifo_empty   = (count == '0);
        hs           = mdu_valid && mdu_ready;
        sel_fifo     = !alu_valid && !fifo_empty;
        sel_direct   = !alu_valid && fifo_empty && hs;
        mdu_sel      = sel_fifo || sel_direct;
        mdu_sel_rd   = sel_fifo ? q_rd[rptr]   : mdu_rd;
        mdu_sel_data = sel_fifo ? q_data[rptr] : mdu_data;
        enq          = hs && !sel_direct;
        deq          = sel_fifo;
        clr_en       = mdu_sel && (mdu_sel_rd != 5'd0);
        issue_busy_int = busy[issue_rd] && !(clr_en && (mdu_sel_rd == issue_rd));
        set_en       = issue_valid && (issue_rd != 5'd0) && !issue_busy_int;
        waw_hit      = (issue_valid && issue_busy_int) ||
                       (alu_valid && (alu_rd != 5'd0) && busy[alu_rd]);
    end

    // A set of the same register wins over a same-cycle clear.
    always_comb begin
        busy_next = busy;
        if (clr_en)
            busy_next[mdu_sel_rd] = 1'b0;
        if (set_en)
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        rf_we  = 1'b0;
        rf_a3  = 5'd0;
        rf_wd3 = '0;
        if (reset) begin
            if (alu_valid) begin
                rf_we  = (alu_rd != 5'd0);
                rf_a3  = alu_rd;
                rf_wd3 = alu_data;
            end else if (mdu_sel) begin
                rf_we  = (mdu_sel_rd != 5'd0);
                rf_a3  = mdu_sel_rd;
                rf_wd3 = mdu_sel_data;
            end
        end
    end

    assign busy1      = busy[chk_a1];
    assign busy2      = busy[chk_a2];
    assign issue_busy = issue_busy_int;
    assign err_waw    = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            busy  <= '0;
            err_q <= 1'b0;
        end else begin
            if (enq)
                wptr <= wptr + 1'b1;
            if (deq)
                rptr <= rptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            busy  <= busy_next;
            err_q <= err_q | waw_hit;
        end
    end

    // Storage needs no reset; emptiness is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_rd[wptr]   <= mdu_rd;
            q_data[wptr] <= mdu_data;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: a queue/bitmap reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_wb_write_arbiter;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid, mdu_valid, issue_valid;
    logic [4:0]      alu_rd, mdu_rd, issue_rd, chk_a1, chk_a2;
    logic [XLEN-1:0] alu_data, mdu_data;
    logic            mdu_ready, busy1, busy2, issue_busy, rf_we, err_waw;
    logic [4:0]      rf_a3;
    logic [XLEN-1:0] rf_wd3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_write_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_a1(chk_a1), .chk_a2(chk_a2), .busy1(busy1), .busy2(busy2), .issue_busy(issue_busy),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .err_waw(err_waw)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: pending MDU results as a queue, pending destinations as a bitmap.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;

    res_t      m_q[$];
    bit [31:0] m_busy = '0;
    bit        m_err  = 1'b0;

    always @(negedge clk) begin : model_cmp
        logic        e_we, e_rdy, e_ib, e_b1, e_b2, hs, wrote_mdu, use_head, direct, alu_hit;
        logic [4:0]  e_a3, w_rd;
        logic [31:0] e_wd;
        e_we = 0; e_a3 = 0; e_wd = 0; e_rdy = 0; e_ib = 0; e_b1 = 0; e_b2 = 0;
        wrote_mdu = 0; use_head = 0; direct = 0; w_rd = 0; hs = 0; alu_hit = 0;
        if (!reset) begin
            m_q.delete();
            m_busy = '0;
            m_err  = 1'b0;
        end else begin
            e_rdy = (m_q.size() < DEPTH);
            hs    = mdu_valid && e_rdy;
            if (alu_valid) begin
                e_we = (alu_rd != 0); e_a3 = alu_rd; e_wd = alu_data;
            end else if (m_q.size() != 0) begin
                e_we = (m_q[0].rd != 0); e_a3 = m_q[0].rd; e_wd = m_q[0].data;
                wrote_mdu = 1; use_head = 1; w_rd = m_q[0].rd;
            end else if (hs) begin
                e_we = (mdu_rd != 0); e_a3 = mdu_rd; e_wd = mdu_data;
                wrote_mdu = 1; direct = 1; w_rd = mdu_rd;
            end
            e_b1 = m_busy[chk_a1];
            e_b2 = m_busy[chk_a2];
            e_ib = m_busy[issue_rd] && !(wrote_mdu && w_rd != 0 && w_rd == issue_rd);
        end
        checkOutput("rf_we",      32'(rf_we),      32'(e_we));
        checkOutput("rf_a3",      32'(rf_a3),      32'(e_a3));
        checkOutput("rf_wd3",     rf_wd3,          e_wd);
        checkOutput("mdu_ready",  32'(mdu_ready),  32'(e_rdy));
        checkOutput("busy1",      32'(busy1),      32'(e_b1));
        checkOutput("busy2",      32'(busy2),      32'(e_b2));
        checkOutput("issue_busy", 32'(issue_busy), 32'(e_ib));
        checkOutput("err_waw",    32'(err_waw),    32'(m_err));
        if (reset) begin
            alu_hit = alu_valid && (alu_rd != 0) && m_busy[alu_rd];
            if (use_head)
                void'(m_q.pop_front());
            if (hs && !direct)
                m_q.push_back(res_t'{rd: mdu_rd, data: mdu_data});
            if (wrote_mdu && w_rd != 0)
                m_busy[w_rd] = 1'b0;
            if (issue_valid && issue_rd != 0 && !e_ib)
                m_busy[issue_rd] = 1'b1;
            m_err = m_err | (issue_valid && e_ib) | alu_hit;
        end
    end

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                 input logic iv, input logic [4:0] ird,
                                 input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #1;
        alu_valid = av;   alu_rd = ard;   alu_data = ad;
        mdu_valid = mv;   mdu_rd = mrd;   mdu_data = md;
        issue_valid = iv; issue_rd = ird;
        chk_a1 = a1;      chk_a2 = a2;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int  k;
        logic rdy;
        reset = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
        issue_valid = 0; issue_rd = 0; chk_a1 = 0; chk_a2 = 0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        sample();
        checkOutput("idle_we",    32'(rf_we),     32'd0);
        checkOutput("idle_ready", 32'(mdu_ready), 32'd1);
        checkOutput("idle_busy1", 32'(busy1),     32'd0);
        checkOutput("idle_err",   32'(err_waw),   32'd0);

        // ALU write, then ALU write to x0
        applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        sample();
        checkOutput("alu_we",  32'(rf_we), 32'd1);
        checkOutput("alu_a3",  32'(rf_a3), 32'd5);
        checkOutput("alu_wd3", rf_wd3,     32'hDEADBEEF);
        applyStimulus(1, 5'd0, 32'h55, 0, 0, 0, 0, 0, 0, 0);
        sample();
        checkOutput("alu_x0_we", 32'(rf_we), 32'd0);

        // Issue rd7, direct MDU write three cycles later
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
        sample();
        checkOutput("iss7_busy1_raw", 32'(busy1), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
        sample();
        checkOutput("iss7_busy1_a", 32'(busy1), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
        sample();
        checkOutput("iss7_busy1_b", 32'(busy1), 32'd1);
        applyStimulus(0, 0, 0, 1, 5'd7, 32'h12345678, 0, 0, 5'd7, 0);
        sample();
        checkOutput("mdu7_we",    32'(rf_we), 32'd1);
        checkOutput("mdu7_a3",    32'(rf_a3), 32'd7);
        checkOutput("mdu7_wd3",   rf_wd3,     32'h12345678);
        checkOutput("mdu7_busy1", 32'(busy1), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
        sample();
        checkOutput("mdu7_cleared", 32'(busy1), 32'd0);

        // ALU hogs the port for 6 cycles; MDU offers rd1..6 and fills the FIFO
        k = 1;
        for (int c = 1; c <= 12; c++) begin
            applyStimulus(c <= 6, 5'(20 + c), 32'(32'hA0 + c), k <= 6, 5'(k), 32'(32'h100 + k),
                          0, 0, 0, 0);
            rdy = mdu_ready;
            sample();
            if (c == 5)
                checkOutput("fifo_full_ready", 32'(mdu_ready), 32'd0);
            if (c >= 7) begin
                checkOutput("order_we",  32'(rf_we), 32'd1);
                checkOutput("order_a3",  32'(rf_a3), 32'(c - 6));
                checkOutput("order_wd3", rf_wd3,     32'(32'h100 + c - 6));
            end
            if (k <= 6 && rdy)
                k++;
        end

        // WAW: second issue of rd9 while pending
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 0);
        sample();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 0);
        sample();
        checkOutput("waw_issue_busy", 32'(issue_busy), 32'd1);
        checkOutput("waw_err_pre",    32'(err_waw),    32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd9, 0);
        sample();
        checkOutput("waw_err_set", 32'(err_waw), 32'd1);
        applyStimulus(0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 5'd9, 0);
        sample();
        checkOutput("mdu9_we",    32'(rf_we), 32'd1);
        checkOutput("mdu9_busy1", 32'(busy1), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0);
        sample();
        checkOutput("mdu9_cleared", 32'(busy1),   32'd0);
        checkOutput("err_sticky",   32'(err_waw), 32'd1);

        // Reset with three queued results and busy[3] set
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd3, 5'd3, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 5'(24 + i), 32'hA5, 1, 5'(13 + i), 32'(32'h200 + i), 0, 0, 5'd3, 0);
        applyStimulus(1, 5'd27, 32'h77, 0, 0, 0, 0, 0, 5'd3, 0);
        reset = 1'b0;
        sample();
        checkOutput("rst_we",    32'(rf_we),     32'd0);
        checkOutput("rst_a3",    32'(rf_a3),     32'd0);
        checkOutput("rst_busy1", 32'(busy1),     32'd0);
        checkOutput("rst_ready", 32'(mdu_ready), 32'd0);
        checkOutput("rst_err",   32'(err_waw),   32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            checkOutput("post_rst_we",    32'(rf_we),     32'd0);
            checkOutput("post_rst_ready", 32'(mdu_ready), 32'd1);
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 0);
        end

        // ALU write to a pending register raises the hazard flag
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd11, 5'd11, 0);
        applyStimulus(1, 5'd11, 32'hB, 0, 0, 0, 0, 0, 5'd11, 0);
        sample();
        checkOutput("alu_haz_we",  32'(rf_we),   32'd1);
        checkOutput("alu_haz_pre", 32'(err_waw), 32'd0);
        applyStimulus(0, 0, 0, 1, 5'd11, 32'hB1, 0, 0, 5'd11, 0);
        sample();
        checkOutput("alu_haz_err", 32'(err_waw), 32'd1);

        // Same-cycle clear and re-issue of rd12 keeps it busy, no hazard
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd12, 5'd12, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd12, 0);
        applyStimulus(0, 0, 0, 1, 5'd12, 32'hC, 1, 5'd12, 5'd12, 0);
        sample();
        checkOutput("setclr_issue_busy", 32'(issue_busy), 32'd0);
        checkOutput("setclr_a3",         32'(rf_a3),      32'd12);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd12, 0);
        sample();
        checkOutput("setclr_busy1", 32'(busy1), 32'd1);

        // MDU result to x0 is consumed without a write
        applyStimulus(0, 0, 0, 1, 5'd0, 32'hF, 0, 0, 5'd12, 0);
        sample();
        checkOutput("mdu_x0_we", 32'(rf_we), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
Drives the single register-file write port (write enable, write address, write data) from two producers.
- Single-cycle ALU results: unconditional priority, zero latency.
- Multi-cycle MDU (mul/div) results: valid/ready handshake, buffered in a small FIFO.
Also holds a 32-entry busy scoreboard of pending MDU destinations, which decode uses for RAW/WAW stall.
Sits between execute/writeback and the register file.

Parameters:
DEPTH, 4, MDU result FIFO entries (power of 2, >=2)
XLEN, 32, data width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU result present this cycle
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
mdu_valid  in  1  MDU result offered
mdu_rd  in  5  MDU destination register
mdu_data  in  XLEN  MDU result
mdu_ready  out  1  FIFO can accept (= not full)
issue_valid  in  1  MDU op issued this cycle
issue_rd  in  5  destination of issued MDU op
chk_a1  in  5  decode source 1
chk_a2  in  5  decode source 2
busy1  out  1  chk_a1 pending
busy2  out  1  chk_a2 pending
issue_busy  out  1  issue_rd pending (WAW, decode must stall)
rf_we  out  1  register-file write enable
rf_a3  out  5  register-file write address
rf_wd3  out  XLEN  register-file write data
err_waw  out  1  sticky hazard-violation flag

Behaviour:
- Reset (reset=0, async): FIFO empty, all busy bits 0, err_waw=0.
- While in reset: rf_we=0, rf_a3=0, rf_wd3=0, mdu_ready=0.
- Reset mid-operation discards all queued results and clears all busy bits.
- Write port is combinational from the current-cycle selection; the register-file write occurs at the next rising edge.
- Source selection priority:
  1. ALU, when alu_valid=1.
  2. FIFO head, when FIFO is non-empty.
  3. Direct MDU input, when FIFO is empty and a handshake occurs.
- ALU selected: rf_we = (alu_rd!=0), rf_a3=alu_rd, rf_wd3=alu_data.
- MDU handshake = mdu_valid && mdu_ready.
  - Handshake result that is not written directly this cycle is enqueued.
  - Direct write (FIFO empty, no alu_valid) bypasses the FIFO: zero latency.
- FIFO head dequeues in any cycle with alu_valid=0.
- Simultaneous enqueue and dequeue allowed; occupancy unchanged.
- mdu_ready = (count < DEPTH), registered from count. No combinational path from mdu_valid.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Any MDU-sourced result with rd=0 is consumed with rf_we=0 and clears nothing.
- Scoreboard:
  - On issue_valid with issue_rd!=0, busy[issue_rd] <= 1.
  - When an MDU-sourced write to rd X is performed, busy[X] <= 0.
  - Same-cycle set and clear of the same X: busy stays 1.
- busy1 = busy[chk_a1], busy2 = busy[chk_a2]. Both 0 for address 0. Raw state; no same-cycle clear bypass.
- issue_busy = busy[issue_rd], excluding a same-cycle clear of issue_rd.
- err_waw sets (sticky until reset) on either:
  - issue_valid while issue_busy=1 (the issue is ignored), or
  - alu_valid with alu_rd!=0 and busy[alu_rd]=1.
- FIFO results retain order: MDU writes reach the register file in handshake order.

Test Plan:
- Reset release, idle -> rf_we=0, mdu_ready=1, busy1=busy2=0, err_waw=0.
- alu_valid=1, rd=5, data=0xDEADBEEF -> same cycle rf_we=1, rf_a3=5, rf_wd3=0xDEADBEEF; alu_rd=0 -> rf_we=0.
- issue rd=7; 3 cycles later MDU result rd=7 data=0x12345678 with FIFO empty, no ALU -> same-cycle write; busy1 (chk_a1=7) is 1 until that edge, then 0.
- ALU valid for 6 consecutive cycles while MDU offers rd=1..6 -> mdu_ready drops after 4 accepts. After ALU stops, writes rd=1,2,3,4 then 5,6 in order; wrap verified.
- Issue rd=9 then issue rd=9 again while busy -> issue_busy=1, err_waw=1 sticky; busy[9] clears only on the single MDU write.
- Assert reset with 3 FIFO entries and busy[3]=1 -> immediately rf_we=0, busy cleared; after release, FIFO empty and no stale writes.
